// File: rtl/scc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scc_pkg
//  Description : Shared sizes, address-map limits and types for the SCC/SCC+
//                wave-table memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package scc_pkg;

    localparam int          SCC_WAVE_BYTES    = 32;
    localparam int          SCC_CHANNELS      = 5;
    localparam int          SCC_WAVE_DEPTH    = 160;
    localparam logic [7:0]  SCC_MAP_LIMIT     = 8'h80;
    localparam logic [7:0]  SCCPLUS_MAP_LIMIT = 8'hA0;
    localparam logic [7:0]  SCC_OPEN_BUS      = 8'hFF;

    // Host pending-buffer states
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pend_state_t;

    // Physical wave index = ch*32 + byte, which is simply {ch, byte}
    function automatic logic [7:0] phys_index(input logic [2:0] ch, input logic [4:0] byte_i);
        return {ch, byte_i};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scc_wave_ram.sv
`default_nettype none
// ============================================================================
//  Module      : scc_wave_ram
//  Description : 160 x 8 single-port synchronous RAM with registered read.
//                Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module scc_wave_ram
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [0:SCC_WAVE_DEPTH-1];
    logic [7:0] r_rdata;

    // Single port: optional write plus registered read of the same address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/scc_wave_memory.sv
`default_nettype none
// ============================================================================
//  Module      : scc_wave_memory
//  Description : SCC/SCC+ wave-table RAM with tone-read priority and a
//                one-entry host pending buffer serviced in idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module scc_wave_memory
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sccplus_mode,
    input  logic       bus_valid,
    input  logic       bus_write,
    input  logic [7:0] bus_address,
    input  logic [7:0] bus_wdata,
    output logic       bus_ready,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_valid,
    input  logic       tone_read,
    input  logic [2:0] tone_channel,
    input  logic [4:0] wave_address,
    output logic [7:0] sample,
    output logic       sample_valid
);

    pend_state_t r_state;
    logic        r_bus_ready;
    logic        r_pend_write;
    logic [7:0]  r_pend_addr;
    logic [7:0]  r_pend_wdata;

    logic        r_tone_pend;
    logic        r_tone_null;
    logic        r_host_rd_pend;
    logic        r_host_oob;
    logic [7:0]  r_sample_hold;
    logic [7:0]  r_rdata_hold;

    logic        w_tone_null;
    logic [2:0]  w_tone_ch;
    logic [7:0]  w_tone_index;
    logic [7:0]  w_host_limit;
    logic        w_host_in_range;
    logic [7:0]  w_host_index;
    logic        w_exec;
    logic        w_ram_we;
    logic [7:0]  w_ram_addr;
    logic [7:0]  w_ram_rdata;

    // Tone side: channels 5..7 read as silence; SCC mode folds channel 4 onto 3
    assign w_tone_null  = (tone_channel > 3'd4);
    assign w_tone_ch    = (!sccplus_mode && (tone_channel == 3'd4)) ? 3'd3 : tone_channel;
    assign w_tone_index = phys_index(w_tone_ch, wave_address);

    // Host side is decoded with the mode in force when the access executes
    assign w_host_limit    = sccplus_mode ? SCCPLUS_MAP_LIMIT : SCC_MAP_LIMIT;
    assign w_host_in_range = (r_pend_addr < w_host_limit);
    assign w_host_index    = sccplus_mode ? r_pend_addr : {1'b0, r_pend_addr[6:0]};

    // A pending host access owns the port only when no tone read is present;
    // reset blocks it so a dropped request never reaches the RAM
    assign w_exec     = (r_state == ST_PENDING) && !tone_read && !reset;
    assign w_ram_we   = w_exec && r_pend_write && w_host_in_range;
    assign w_ram_addr = tone_read ? w_tone_index : w_host_index;

    scc_wave_ram u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_pend_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Pending-buffer FSM: capture one host request, release it in a free cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bus_ready  <= 1'b1;
            r_pend_write <= 1'b0;
            r_pend_addr  <= 8'h00;
            r_pend_wdata <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_valid) begin
                        r_pend_write <= bus_write;
                        r_pend_addr  <= bus_address;
                        r_pend_wdata <= bus_wdata;
                        r_bus_ready  <= 1'b0;
                        r_state      <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!tone_read) begin
                        r_bus_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Track which requester owns the RAM output this cycle and hold last results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tone_pend    <= 1'b0;
            r_tone_null    <= 1'b0;
            r_host_rd_pend <= 1'b0;
            r_host_oob     <= 1'b0;
            r_sample_hold  <= 8'h00;
            r_rdata_hold   <= 8'h00;
        end else begin
            r_tone_pend    <= tone_read;
            r_tone_null    <= w_tone_null;
            r_host_rd_pend <= w_exec && !r_pend_write;
            r_host_oob     <= !w_host_in_range;
            if (r_tone_pend) begin
                r_sample_hold <= sample;
            end
            if (r_host_rd_pend) begin
                r_rdata_hold <= bus_rdata;
            end
        end
    end

    assign sample          = r_tone_pend ? (r_tone_null ? 8'h00 : w_ram_rdata) : r_sample_hold;
    assign sample_valid    = r_tone_pend;
    assign bus_rdata       = r_host_rd_pend ? (r_host_oob ? SCC_OPEN_BUS : w_ram_rdata) : r_rdata_hold;
    assign bus_rdata_valid = r_host_rd_pend;
    assign bus_ready       = r_bus_ready;

endmodule
`default_nettype wire

// File: doc/scc_wave_memory.md
# scc_wave_memory

Wave-table RAM and access arbiter for the SCC/SCC+ sound core. It holds the 32-byte waveforms of all five channels. Bus writes and reads from the host side go in through a one-entry pending buffer. The sample at the address issued by the channel tone generators comes back on a one-cycle read port. Tone-generator reads always win the single RAM port, and host accesses are serviced in idle cycles.

## Interface
- No parameters. Sizes are fixed constants in the shared package.
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sccplus_mode  input  1  0 = SCC map (channels 3/4 share a wave), 1 = SCC+ map (five independent waves)
- bus_valid  input  1  host access request
- bus_write  input  1  1 = write, 0 = read (sampled with bus_valid)
- bus_address  input  8  wave-area byte address
- bus_wdata  input  8  write data
- bus_ready  output  1  request accepted when bus_valid && bus_ready
- bus_rdata  output  8  host read data
- bus_rdata_valid  output  1  one-cycle strobe qualifying bus_rdata
- tone_read  input  1  tone-generator sample request
- tone_channel  input  3  channel 0..4
- wave_address  input  5  byte index within the channel's wave
- sample  output  8  signed sample (two's complement)
- sample_valid  output  1  one-cycle strobe qualifying sample

## Operation
**Storage**
- 160 × 8 bits, physical index = ch*32 + byte.
- Contents are not cleared by reset.

**Host address map, SCC mode**
- 0x00–0x7F → ch = addr[6:5], byte = addr[4:0].
- 0x80–0xFF: writes discarded; reads return 0xFF.

**Host address map, SCC+ mode**
- 0x00–0x9F → ch = addr[7:5], byte = addr[4:0].
- 0xA0–0xFF: writes discarded; reads return 0xFF.

**Tone reads**
- SCC mode: tone_channel 4 reads channel 3's storage.
- SCC+ mode: direct mapping.
- tone_channel 5–7 returns sample 0x00 with sample_valid still asserted.

**Pending buffer states**
- IDLE:
  - bus_ready = 1.
  - On bus_valid, latch write/address/wdata and go to PENDING.
- PENDING:
  - bus_ready = 0; new bus_valid is ignored, and the host holds its request.
  - In the first cycle with tone_read = 0, perform the access and go to IDLE.
  - Out-of-range accesses also wait for a free cycle, so latency is uniform.

**Arbitration and mode changes**
- tone_read has absolute priority. A continuous tone_read stalls the host indefinitely; this is by design, since the upstream sequencer guarantees idle slots.
- A sccplus_mode change takes effect for any access executed after it. A pending request is decoded with the mode value at execution time.

## Timing
**Reset values**
- sample = 0x00, sample_valid = 0.
- bus_ready = 1, bus_rdata = 0x00, bus_rdata_valid = 0.
- State = IDLE. Any pending request is dropped with no write and no rdata strobe.

**Tone read**
- Request in cycle N → sample and sample_valid in N+1.
- sample holds its value until the next tone read.

**Host access**
- Accepted in cycle A (PENDING from A+1).
- Executes in the first cycle E ≥ A+1 with tone_read = 0.
- Write: RAM is updated at the end of E.
- Read: bus_rdata and bus_rdata_valid appear in E+1. bus_rdata holds its value afterwards.
- bus_ready is high again in E+1. Minimum request-to-request spacing is 2 cycles.

**Read-after-write**
- A tone read in the cycle after a host write to the same byte returns the new value.
- There is no same-cycle collision, because there is a single port.

## Structure
**Shared package (scc_pkg)**
- SCC_WAVE_BYTES = 32
- SCC_CHANNELS = 5
- SCC_WAVE_DEPTH = 160
- SCC_MAP_LIMIT = 0x80
- SCCPLUS_MAP_LIMIT = 0xA0
- SCC_OPEN_BUS = 0xFF

**Sub-module scc_wave_ram**
- 160×8 single-port synchronous RAM with a registered read, suitable for block-RAM inference.
- Address decode, channel aliasing and the pending FSM stay in scc_wave_memory.

## Test plan
1. **Basic write / tone read:** SCC+ mode, write 0x9F←0x7F, then tone_read ch4 addr 31 → sample 0x7F one cycle later.
2. **SCC aliasing:** SCC mode, write 0x65←0x80, then tone_read ch4 addr 5 and ch3 addr 5 → both 0x80.
3. **Open bus:** SCC mode, read 0x90 → bus_rdata 0xFF; write 0x90←0x12, then SCC+ read 0x90 → not 0x12.
4. **Arbitration stall:** bus read 0x21 issued while tone_read is held for 4 cycles → bus_ready low for exactly 5 cycles; rdata_valid in the cycle after tone_read drops.
5. **Reset mid-operation:** write 0x10←0xAA pending under a tone_read stall, then assert reset → no write occurs (prior 0x10 contents unchanged), bus_ready = 1, and both valid strobes 0 after reset.
6. **Back-to-back traffic:** alternating tone reads and host writes over all 160 bytes → scoreboard matches every sample; no request is lost.
